// File: rtl/dmem_arbiter_if.sv
// Bundles the pipeline, debug and data-memory buses of dmem_arbiter.
// The dbg_lock signal exists only when DMEM_ARB_LOCK_EN is defined.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              pipe_rd;
  logic              pipe_wr;
  logic [ADDR_W-1:0] pipe_addr;
  logic [DATA_W-1:0] pipe_wdata;
  logic [DATA_W-1:0] pipe_rdata;
  logic              pipe_stall;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
`ifdef DMEM_ARB_LOCK_EN
  logic              dbg_lock;
`endif
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;

  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  pipe_rd, pipe_wr, pipe_addr, pipe_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
`ifdef DMEM_ARB_LOCK_EN
    input  dbg_lock,
`endif
    input  mem_rdata,
    output pipe_rdata, pipe_stall, dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_rd, mem_wr, mem_addr, mem_wdata
  );

  // Requester/memory side.
  modport master (
    output pipe_rd, pipe_wr, pipe_addr, pipe_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
`ifdef DMEM_ARB_LOCK_EN
    output dbg_lock,
`endif
    output mem_rdata,
    input  pipe_rdata, pipe_stall, dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_rd, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: pipeline has priority, debug port uses idle slots or a forced
// slot after STARVE_LIMIT waits. Locked debug bursts are enabled by DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
`ifdef DMEM_ARB_LOCK_EN
  , parameter int LOCK_MAX   = 16
`endif
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus,
  output logic          dbg_state_o
);
  // Handshake: pipe_rd/pipe_wr and dbg_req are valids held until accepted; the pipeline
  // is accepted in a cycle with pipe_stall=0, the debug port in a cycle with dbg_gnt=1.
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic {S_RUN = 1'b0, S_LOCK = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic              dbg_rvalid_q, dbg_rvalid_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
`ifdef DMEM_ARB_LOCK_EN
  localparam int             LCW       = $clog2(LOCK_MAX + 1);
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_MAX - 1);
  logic [LCW-1:0]    lock_cnt_q, lock_cnt_d;
`endif

  logic              pipe_act;
  logic              starve_hit;
  logic              dbg_own;
  logic              pipe_own;
  logic              stall;
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RUN;
      starve_q     <= '0;
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= '0;
`ifdef DMEM_ARB_LOCK_EN
      lock_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      dbg_rdata_q  <= dbg_rdata_d;
`ifdef DMEM_ARB_LOCK_EN
      lock_cnt_q   <= lock_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d      = S_RUN;
    dbg_rvalid_d = dbg_own & ~bus.dbg_we;
    dbg_rdata_d  = dbg_rvalid_d ? bus.mem_rdata : dbg_rdata_q;
    if (dbg_own || !bus.dbg_req)
      starve_d = '0;
    else if (starve_q == STARVE_MAX)
      starve_d = starve_q;
    else
      starve_d = starve_q + 4'd1;
`ifdef DMEM_ARB_LOCK_EN
    // lock_cnt counts every beat of the burst, entry grant included.
    lock_cnt_d = lock_cnt_q;
    unique case (state_q)
      S_RUN: begin
        if (dbg_own && bus.dbg_lock) begin
          state_d    = S_LOCK;
          lock_cnt_d = LCW'(1);
        end
      end
      S_LOCK: begin
        state_d = S_LOCK;
        if (dbg_own)
          lock_cnt_d = lock_cnt_q + LCW'(1);
        if (!bus.dbg_lock || !bus.dbg_req || lock_cnt_q == LOCK_LAST) begin
          state_d    = S_RUN;
          lock_cnt_d = '0;
        end
      end
      default: ;
    endcase
`endif
  end

  always_comb begin
    pipe_act   = bus.pipe_rd | bus.pipe_wr;
    starve_hit = bus.dbg_req && (starve_q == STARVE_MAX);
    dbg_own    = 1'b0;
    pipe_own   = 1'b0;
    stall      = 1'b0;
    if (!rst) begin
      if (state_q == S_LOCK) begin
        dbg_own = bus.dbg_req;
        stall   = pipe_act;
      end else if (starve_hit) begin
        dbg_own = 1'b1;
        stall   = pipe_act;
      end else if (pipe_act) begin
        pipe_own = 1'b1;
      end else begin
        dbg_own = bus.dbg_req;
      end
    end
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = bus.pipe_addr;
    mem_wdata = bus.pipe_wdata;
    if (dbg_own) begin
      mem_wr    = bus.dbg_we;
      mem_rd    = ~bus.dbg_we;
      mem_addr  = bus.dbg_addr;
      mem_wdata = bus.dbg_wdata;
    end else if (pipe_own) begin
      mem_wr = bus.pipe_wr;
      mem_rd = bus.pipe_rd & ~bus.pipe_wr;
    end
  end

  assign bus.dbg_gnt    = dbg_own;
  assign bus.pipe_stall = stall;
  assign bus.pipe_rdata = bus.mem_rdata;
  assign bus.dbg_rvalid = dbg_rvalid_q;
  assign bus.dbg_rdata  = dbg_rdata_q;
  assign bus.mem_rd     = mem_rd;
  assign bus.mem_wr     = mem_wr;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;
  assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized run
// checked against a cycle-level reference of the arbitration rules.
module tb_dmem_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int SL = 4;
`ifdef DMEM_ARB_LOCK_EN
  localparam int LM = 16;
`endif

  logic clk = 1'b0;
  logic rst;
  logic mem_clr;
  logic dbg_state;
  logic [DW-1:0] mem_arr [0:255];
  logic [DW-1:0] ref_mem [0:255];
  logic [DW-1:0] exp_q[$];
  int total = 0;
  int bad = 0;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)
`ifdef DMEM_ARB_LOCK_EN
    , .LOCK_MAX(LM)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .dbg_state_o(dbg_state)
  );

  // clock / memory model
  always #5 clk = ~clk;
  assign bus.mem_rdata = mem_arr[bus.mem_addr];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= '0;
    end else if (bus.mem_wr) begin
      mem_arr[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic drive_pipe(input logic rd, input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
    bus.pipe_rd = rd; bus.pipe_wr = wr; bus.pipe_addr = a; bus.pipe_wdata = d;
  endtask

  task automatic drive_dbg(input logic req, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    bus.dbg_req = req; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = d;
  endtask

  task automatic drive_lock(input logic l);
`ifdef DMEM_ARB_LOCK_EN
    bus.dbg_lock = l;
`else
    if (l) $display("note: lock request ignored in this build");
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_clr = 1'b1;
    drive_pipe(1'b0, 1'b1, 8'h10, 32'h12345678);
    drive_dbg(1'b1, 1'b1, 8'h10, 32'h87654321);
    drive_lock(1'b0);
    repeat (2) @(negedge clk);
    #2;
    total++; if (bus.dbg_gnt !== 1'b0) begin bad++; $display("FAIL rst_gnt got=%b want=0", bus.dbg_gnt); end
    total++; if (bus.pipe_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b want=0", bus.pipe_stall); end
    total++; if (bus.mem_wr !== 1'b0 || bus.mem_rd !== 1'b0) begin bad++; $display("FAIL rst_strobes got=%b%b want=00", bus.mem_wr, bus.mem_rd); end
    total++; if (bus.dbg_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%b want=0", bus.dbg_rvalid); end
    total++; if (bus.dbg_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0", bus.dbg_rdata); end
    total++; if (dbg_state !== 1'b0) begin bad++; $display("FAIL rst_state got=%b want=0", dbg_state); end
    @(negedge clk);
    rst = 1'b0; mem_clr = 1'b0;
    drive_pipe(1'b0, 1'b0, 8'h0, 32'h0);
    drive_dbg(1'b0, 1'b0, 8'h0, 32'h0);
  endtask

  task automatic test_pipe_only();
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (c < 10) drive_pipe(1'b0, 1'b1, 8'h10, 32'hDEADBEEF);
      else        drive_pipe(1'b1, 1'b0, 8'h10, 32'h0);
      #2;
      total++; if (bus.pipe_stall !== 1'b0 || bus.dbg_gnt !== 1'b0) begin bad++; $display("FAIL pipe_only_ctl c=%0d stall=%b gnt=%b want 0 0", c, bus.pipe_stall, bus.dbg_gnt); end
      total++; if (bus.mem_wr !== (c < 10) || bus.mem_rd !== (c == 10)) begin bad++; $display("FAIL pipe_only_strobe c=%0d wr=%b rd=%b", c, bus.mem_wr, bus.mem_rd); end
    end
    total++; if (bus.pipe_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL pipe_only_rdata got=%h want=deadbeef", bus.pipe_rdata); end
    @(negedge clk);
    drive_pipe(1'b0, 1'b0, 8'h0, 32'h0);
  endtask

  task automatic test_idle_dbg_read();
    drive_dbg(1'b1, 1'b0, 8'h10, 32'h0);
    #2;
    total++; if (bus.dbg_gnt !== 1'b1) begin bad++; $display("FAIL idle_rd_gnt got=%b want=1", bus.dbg_gnt); end
    total++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 8'h10) begin bad++; $display("FAIL idle_rd_mem rd=%b addr=%h want 1 10", bus.mem_rd, bus.mem_addr); end
    @(negedge clk);
    drive_dbg(1'b0, 1'b0, 8'h0, 32'h0);
    #2;
    total++; if (bus.dbg_rvalid !== 1'b1) begin bad++; $display("FAIL idle_rd_rvalid got=%b want=1", bus.dbg_rvalid); end
    total++; if (bus.dbg_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL idle_rd_rdata got=%h want=deadbeef", bus.dbg_rdata); end
    @(negedge clk);
    #2;
    total++; if (bus.dbg_rvalid !== 1'b0) begin bad++; $display("FAIL idle_rd_rvalid_drop got=%b want=0", bus.dbg_rvalid); end
  endtask

  task automatic test_starvation();
    for (int c = 1; c <= SL + 2; c++) begin
      @(negedge clk);
      drive_pipe(1'b1, 1'b0, 8'h10, 32'h0);
      if (c <= SL + 1) drive_dbg(1'b1, 1'b0, 8'h10, 32'h0);
      else             drive_dbg(1'b0, 1'b0, 8'h0, 32'h0);
      #2;
      total++; if (bus.dbg_gnt !== (c == SL + 1)) begin bad++; $display("FAIL starve_gnt c=%0d got=%b want=%b", c, bus.dbg_gnt, c == SL + 1); end
      total++; if (bus.pipe_stall !== (c == SL + 1)) begin bad++; $display("FAIL starve_stall c=%0d got=%b want=%b", c, bus.pipe_stall, c == SL + 1); end
      total++; if (bus.mem_rd !== 1'b1) begin bad++; $display("FAIL starve_rd c=%0d got=%b want=1", c, bus.mem_rd); end
    end
    total++; if (bus.pipe_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL starve_pipe_rdata got=%h want=deadbeef", bus.pipe_rdata); end
    total++; if (bus.dbg_rvalid !== 1'b1 || bus.dbg_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL starve_dbg_ret rv=%b data=%h want 1 deadbeef", bus.dbg_rvalid, bus.dbg_rdata); end
  endtask

  task automatic test_same_addr();
    for (int c = 1; c <= SL + 2; c++) begin
      @(negedge clk);
      if (c <= SL + 1) begin
        drive_pipe(1'b0, 1'b1, 8'h20, 32'h11111111);
        drive_dbg(1'b1, 1'b1, 8'h20, 32'h22222222);
      end else begin
        drive_pipe(1'b1, 1'b0, 8'h20, 32'h0);
        drive_dbg(1'b0, 1'b0, 8'h0, 32'h0);
      end
      #2;
      if (c == 1) begin
        total++; if (bus.mem_wr !== 1'b1 || bus.mem_wdata !== 32'h11111111 || bus.dbg_gnt !== 1'b0) begin bad++; $display("FAIL same_first wr=%b data=%h gnt=%b", bus.mem_wr, bus.mem_wdata, bus.dbg_gnt); end
      end
      if (c == 2) begin
        total++; if (bus.pipe_rdata !== 32'h11111111) begin bad++; $display("FAIL same_pipe_landed got=%h want=11111111", bus.pipe_rdata); end
      end
      if (c == SL + 1) begin
        total++; if (bus.dbg_gnt !== 1'b1 || bus.pipe_stall !== 1'b1 || bus.mem_wdata !== 32'h22222222) begin bad++; $display("FAIL same_forced gnt=%b stall=%b data=%h", bus.dbg_gnt, bus.pipe_stall, bus.mem_wdata); end
      end
    end
    total++; if (bus.pipe_rdata !== 32'h22222222) begin bad++; $display("FAIL same_final got=%h want=22222222", bus.pipe_rdata); end
  endtask

  task automatic test_random();
    int waited = 0;
    logic hold_pipe = 1'b0;
    logic d_pend = 1'b0;
    logic exp_rv = 1'b0;
    logic p_rd = 1'b0, p_wr = 1'b0, pact, e_gnt, e_stall, e_wr, e_rd;
    logic [AW-1:0] p_a = '0;
    logic [DW-1:0] p_d = '0, e_data;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    exp_q.delete();
    @(negedge clk);
    drive_pipe(1'b0, 1'b0, 8'h0, 32'h0);
    drive_dbg(1'b0, 1'b0, 8'h0, 32'h0);
    for (int n = 0; n <= 400; n++) begin
      @(negedge clk);
      if (n == 400) begin
        hold_pipe = 1'b0; p_rd = 1'b0; p_wr = 1'b0; d_pend = 1'b0;
        drive_dbg(1'b0, 1'b0, 8'h0, 32'h0);
      end else begin
        if (!hold_pipe) begin
          case ($urandom_range(0, 3))
            0:       begin p_rd = 1'b0; p_wr = 1'b0; end
            1:       begin p_rd = 1'b1; p_wr = 1'b0; end
            2:       begin p_rd = 1'b0; p_wr = 1'b1; end
            default: begin p_rd = 1'b1; p_wr = 1'b1; end
          endcase
          p_a = 8'h40 + 8'($urandom_range(0, 15));
          p_d = $urandom;
        end
        if (!d_pend) begin
          if ($urandom_range(0, 1) == 1)
            drive_dbg(1'b1, 1'($urandom_range(0, 1)), 8'h40 + 8'($urandom_range(0, 15)), $urandom);
          else
            drive_dbg(1'b0, 1'b0, 8'h0, 32'h0);
        end
      end
      drive_pipe(p_rd, p_wr, p_a, p_d);
      #2;
      pact    = p_rd | p_wr;
      e_gnt   = bus.dbg_req && (waited == SL || !pact);
      e_stall = bus.dbg_req && waited == SL && pact;
      e_wr = 1'b0; e_rd = 1'b0;
      if (e_gnt) begin e_wr = bus.dbg_we; e_rd = ~bus.dbg_we; end
      else if (pact) begin e_wr = p_wr; e_rd = p_rd & ~p_wr; end
      total++; if (bus.dbg_rvalid !== exp_rv) begin bad++; $display("FAIL rnd_rvalid n=%0d got=%b want=%b", n, bus.dbg_rvalid, exp_rv); end
      if (exp_rv && exp_q.size() > 0) begin
        e_data = exp_q.pop_front();
        total++; if (bus.dbg_rdata !== e_data) begin bad++; $display("FAIL rnd_rdata n=%0d got=%h want=%h", n, bus.dbg_rdata, e_data); end
      end
      total++; if (bus.dbg_gnt !== e_gnt) begin bad++; $display("FAIL rnd_gnt n=%0d got=%b want=%b", n, bus.dbg_gnt, e_gnt); end
      total++; if (bus.pipe_stall !== e_stall) begin bad++; $display("FAIL rnd_stall n=%0d got=%b want=%b", n, bus.pipe_stall, e_stall); end
      total++; if (bus.mem_wr !== e_wr || bus.mem_rd !== e_rd) begin bad++; $display("FAIL rnd_strobe n=%0d got=%b%b want=%b%b", n, bus.mem_wr, bus.mem_rd, e_wr, e_rd); end
      if (!e_gnt && pact && !p_wr) begin
        total++; if (bus.pipe_rdata !== ref_mem[p_a]) begin bad++; $display("FAIL rnd_pipe_rdata n=%0d got=%h want=%h", n, bus.pipe_rdata, ref_mem[p_a]); end
      end
      exp_rv = 1'b0;
      if (e_gnt) begin
        if (bus.dbg_we) ref_mem[bus.dbg_addr] = bus.dbg_wdata;
        else begin exp_q.push_back(ref_mem[bus.dbg_addr]); exp_rv = 1'b1; end
      end else if (pact && p_wr) begin
        ref_mem[p_a] = p_d;
      end
      if (e_gnt || !bus.dbg_req) waited = 0;
      else if (waited < SL) waited++;
      hold_pipe = e_stall;
      d_pend = bus.dbg_req && !e_gnt;
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive_pipe(1'b0, 1'b0, 8'h0, 32'h0);
    drive_dbg(1'b1, 1'b0, 8'h10, 32'h0);
    drive_lock(1'b0);
    #2;
    total++; if (bus.dbg_gnt !== 1'b1) begin bad++; $display("FAIL rmid_gnt got=%b want=1", bus.dbg_gnt); end
    @(negedge clk);
    rst = 1'b1;
    drive_pipe(1'b0, 1'b1, 8'h10, 32'h0BAD0BAD);
    drive_dbg(1'b1, 1'b1, 8'h10, 32'h0BAD0BAD);
    #2;
    total++; if (bus.mem_wr !== 1'b0 || bus.dbg_gnt !== 1'b0 || bus.pipe_stall !== 1'b0) begin bad++; $display("FAIL rmid_in_rst wr=%b gnt=%b stall=%b want 0 0 0", bus.mem_wr, bus.dbg_gnt, bus.pipe_stall); end
    @(negedge clk);
    rst = 1'b0;
    drive_pipe(1'b1, 1'b0, 8'h10, 32'h0);
    drive_dbg(1'b0, 1'b0, 8'h0, 32'h0);
    #2;
    total++; if (bus.dbg_rvalid !== 1'b0 || bus.dbg_rdata !== 32'h0) begin bad++; $display("FAIL rmid_after rv=%b data=%h want 0 0", bus.dbg_rvalid, bus.dbg_rdata); end
    total++; if (bus.pipe_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rmid_nowrite got=%h want=deadbeef", bus.pipe_rdata); end
  endtask

`ifdef DMEM_ARB_LOCK_EN
  task automatic test_lock();
    int beats = 0;
    @(negedge clk);
    drive_pipe(1'b0, 1'b0, 8'h0, 32'h0);
    drive_dbg(1'b0, 1'b0, 8'h0, 32'h0);
    drive_lock(1'b0);
    for (int c = 1; c <= SL + LM + 1; c++) begin
      @(negedge clk);
      drive_pipe(1'b1, 1'b0, 8'h10, 32'h0);
      drive_dbg(1'b1, 1'b1, 8'h30 + 8'(beats), 32'(beats));
      drive_lock(1'b1);
      #2;
      total++; if (bus.dbg_gnt !== (c > SL && c <= SL + LM)) begin bad++; $display("FAIL lock_gnt c=%0d got=%b", c, bus.dbg_gnt); end
      total++; if (bus.pipe_stall !== (c > SL && c <= SL + LM)) begin bad++; $display("FAIL lock_stall c=%0d got=%b", c, bus.pipe_stall); end
      total++; if (dbg_state !== (c > SL + 1 && c <= SL + LM)) begin bad++; $display("FAIL lock_state c=%0d got=%b", c, dbg_state); end
      if (bus.dbg_gnt === 1'b1) beats++;
    end
    total++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 8'h10) begin bad++; $display("FAIL lock_pipe_after rd=%b addr=%h", bus.mem_rd, bus.mem_addr); end
    // reset during a burst
    @(negedge clk);
    drive_pipe(1'b0, 1'b0, 8'h0, 32'h0);
    drive_dbg(1'b1, 1'b0, 8'h10, 32'h0);
    @(negedge clk);
    #2;
    total++; if (dbg_state !== 1'b1 || bus.dbg_gnt !== 1'b1) begin bad++; $display("FAIL lrst_in_lock state=%b gnt=%b want 1 1", dbg_state, bus.dbg_gnt); end
    @(negedge clk);
    rst = 1'b1;
    drive_dbg(1'b1, 1'b1, 8'h10, 32'h0BAD0BAD);
    #2;
    total++; if (bus.mem_wr !== 1'b0 || bus.dbg_gnt !== 1'b0) begin bad++; $display("FAIL lrst_wr wr=%b gnt=%b want 0 0", bus.mem_wr, bus.dbg_gnt); end
    @(negedge clk);
    rst = 1'b0;
    drive_dbg(1'b0, 1'b0, 8'h0, 32'h0);
    drive_lock(1'b0);
    drive_pipe(1'b1, 1'b0, 8'h10, 32'h0);
    #2;
    total++; if (dbg_state !== 1'b0 || bus.dbg_rvalid !== 1'b0) begin bad++; $display("FAIL lrst_after state=%b rv=%b want 0 0", dbg_state, bus.dbg_rvalid); end
    total++; if (bus.pipe_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL lrst_nowrite got=%h want=deadbeef", bus.pipe_rdata); end
  endtask
`endif

  initial begin
    test_reset();
    test_pipe_only();
    test_idle_dbg_read();
    test_starvation();
    test_same_addr();
    test_random();
    test_reset_mid();
`ifdef DMEM_ARB_LOCK_EN
    test_lock();
`endif
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory between the pipeline's memory stage and an external debug/loader port. The pipeline has priority; the debug port is served in idle memory-stage cycles. A starvation counter forces a debug slot by stalling the pipeline for one cycle. The block sits between the XM forwarding output and the data memory, and its stall output is ORed into the hazard unit's stall.

## Interface
Parameters:
- ADDR_W, 8, data memory word-address width
- DATA_W, 32, data word width
- STARVE_LIMIT, 4, consecutive ungranted debug-request cycles before a forced debug slot (legal range 1–15)
- LOCK_MAX, 16, maximum beats in one locked debug burst (used only with DMEM_ARB_LOCK_EN)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- pipe_rd  in  1  memory-stage read request
- pipe_wr  in  1  memory-stage write request; wins over pipe_rd if both are set
- pipe_addr  in  ADDR_W  memory-stage address
- pipe_wdata  in  DATA_W  memory-stage write data
- pipe_rdata  out  DATA_W  mem_rdata passthrough
- pipe_stall  out  1  pipeline must hold the memory stage and all stages upstream of it this cycle
- dbg_req  in  1  debug access request; held until granted
- dbg_we  in  1  debug write (1) or read (0)
- dbg_addr  in  ADDR_W  debug address
- dbg_wdata  in  DATA_W  debug write data
- dbg_lock  in  1  request a locked burst (port present only with DMEM_ARB_LOCK_EN)
- dbg_gnt  out  1  debug access performed this cycle
- dbg_rvalid  out  1  registered: the debug read granted last cycle has returned
- dbg_rdata  out  DATA_W  registered read data
- mem_rd, mem_wr  out  1  memory strobes
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  combinational read data; the write commits on the clk edge

## Operation
- pipe_act = pipe_rd | pipe_wr.
- State RUN:
  - If dbg_req and starve_cnt == STARVE_LIMIT: the debug port gets the slot. dbg_gnt=1, and pipe_stall=pipe_act. The pipeline request is held and served next cycle.
  - Else if pipe_act: the pipeline gets the slot. dbg_gnt=0 and pipe_stall=0.
  - Else if dbg_req: the debug port gets the slot and dbg_gnt=1.
  - Else: no access, and the mem strobes are 0.
- starve_cnt:
  - cleared when dbg_gnt=1 or dbg_req=0
  - otherwise incremented, saturating at STARVE_LIMIT
- Muxing:
  - When the debug port owns the slot, the mem_* outputs are driven from dbg_*: mem_wr=dbg_we, mem_rd=~dbg_we.
  - Otherwise the mem_* outputs are driven from pipe_*.
  - Strobes are never asserted for a requester that does not own the slot.
- Read return: on a granted debug read, dbg_rdata<=mem_rdata and dbg_rvalid<=1 at the next edge; otherwise dbg_rvalid<=0.
- State LOCK (DMEM_ARB_LOCK_EN only):
  - Entered when dbg_gnt=1 and dbg_lock=1 in RUN.
  - In LOCK: dbg_gnt=dbg_req, pipe_stall=pipe_act, and lock_cnt increments on each granted beat.
  - Leave to RUN after a cycle in which dbg_lock=0, dbg_req=0, or lock_cnt reaches LOCK_MAX-1.
  - On entry to RUN, starve_cnt=0.
- Reset:
  - state=RUN, starve_cnt=0, lock_cnt=0, dbg_rvalid=0, dbg_rdata=0.
  - While rst=1: dbg_gnt=0, pipe_stall=0, mem_rd=mem_wr=0.
  - Reset mid-LOCK returns to RUN, and no write occurs in the reset cycle.

## Timing
- dbg_gnt, pipe_stall and mem_* are combinational (Mealy) from the requests and the current state, with zero-cycle grant latency.
- Debug read data appears 1 cycle after dbg_gnt.
- Worst-case debug wait under continuous pipeline traffic: STARVE_LIMIT cycles of waiting, then a grant in cycle STARVE_LIMIT+1.
- A forced slot costs the pipeline exactly 1 stall cycle; a locked burst costs at most LOCK_MAX.
- The debug port must hold dbg_addr, dbg_we and dbg_wdata stable while dbg_req=1 and dbg_gnt=0.
- There is no combinational path from pipe_stall back to pipe_rd or pipe_wr inside the block.

## Configuration
- DMEM_ARB_LOCK_EN defined: the dbg_lock port, the LOCK state, lock_cnt and LOCK_MAX are present.
- DMEM_ARB_LOCK_EN undefined: none of these exist. Every grant is a single beat, and the FSM is RUN only.

## Test plan
- Pipeline-only traffic: 10 cycles of pipe_wr to addr 0x10 with data 0xDEADBEEF, then pipe_rd of 0x10 -> pipe_rdata=0xDEADBEEF; pipe_stall and dbg_gnt stay 0 throughout.
- Idle-slot debug read: pipe idle, dbg_req=1, dbg_we=0, addr 0x10 -> dbg_gnt=1 the same cycle; next cycle dbg_rvalid=1 with dbg_rdata=0xDEADBEEF.
- Starvation: continuous pipe_rd with dbg_req held, STARVE_LIMIT=4 -> dbg_gnt=0 for 4 cycles; in cycle 5, dbg_gnt=1 and pipe_stall=1; in cycle 6, the pipeline is served with pipe_stall=0.
- Simultaneous pipe_wr and debug write to the same address, with starve_cnt below the limit -> the pipeline write lands first; after the forced slot the memory holds the debug data.
- Lock burst (DMEM_ARB_LOCK_EN, LOCK_MAX=16), dbg_lock held with continuous requests -> exactly 16 consecutive grants with pipe_stall=1 while pipe_act; then RUN, and the pipeline is served.
- rst asserted during a LOCK burst with dbg_we=1 -> mem_wr=0 that cycle; after reset, state=RUN and dbg_rvalid=0.
